tdr_sweep_capture: RTL
======================

// Module: tdr_sweep_capture
// PURPOSE
//  Equivalent-time TDR acquisition engine. Sweeps the sample delay across
//  NUM_TAPS taps and fires AVG_COUNT launch pulses per tap. Counts the 1-samples
//  of reflected_signal at each tap, streams one point per tap and reports the
//  first tap whose count reaches threshold (fault location). Drives the launch
//  pin and reflection model in place of the fixed-delay single-shot core.
// PARAMETERS
//  NUM_TAPS      64  taps per sweep; tap k samples k*TAP_STEP cycles after launch
//  TAP_STEP      1   cycles between consecutive taps (>=1)
//  AVG_COUNT     16  launches per tap (>=1)
//  PULSE_WIDTH   4   cycles tx_drive is held high per launch (>=1)
//  SETTLE_CYCLES 32  quiet cycles after each sample before the next launch
// PORTS
//  clk          in   1    system clock
//  rst          in   1    synchronous, active-high reset
//  start        in   1    pulse; begins a sweep when idle
//  abort        in   1    pulse; terminates the sweep in progress
//  threshold    in   CW   edge threshold, latched at start; CW=$clog2(AVG_COUNT+1)
//  reflected_signal in 1  return from line / reflection model
//  tx_drive     out  1    launch pulse to line
//  pulse_out    out  1    one-cycle strobe on first cycle of each launch
//  busy         out  1    high from accepted start until done/abort
//  pt_valid     out  1    one-cycle strobe: point ready
//  pt_index     out  TW   tap index of point; TW=$clog2(NUM_TAPS)
//  pt_count     out  CW   number of 1-samples at that tap (0..AVG_COUNT)
//  done         out  1    one-cycle strobe after last point of a full sweep
//  edge_found   out  1    result valid; held until next accepted start
//  edge_index   out  TW   first tap with pt_count >= threshold
// BEHAVIOUR
//  Reset: every output is 0; FSM IDLE; counters and accumulator cleared.
//  FSM: IDLE -> LAUNCH -> WAIT -> SAMPLE -> SETTLE -> (LAUNCH | EMIT).
//    EMIT -> LAUNCH (next tap) | DONE; DONE -> IDLE.
//  IDLE: start=1 latches threshold, clears edge_found/edge_index,
//    sets tap=0, rep=0 and acc=0. Next state is LAUNCH and busy=1.
//  LAUNCH: tx_drive=1 for PULSE_WIDTH cycles. pulse_out=1 on the first cycle (t0).
//  Sample timing: reflected_signal is registered on cycle t0 + tap*TAP_STEP.
//    This holds even when the sample falls inside the launch window (tap 0).
//    The delay counter runs from t0 independently of tx_drive.
//  SAMPLE: acc += reflected_signal. acc saturates at AVG_COUNT; it cannot overflow.
//  SETTLE: tx_drive=0 for SETTLE_CYCLES, then rep++.
//    If rep < AVG_COUNT -> LAUNCH, else -> EMIT.
//  EMIT (1 cycle): pt_valid=1, pt_index=tap, pt_count=acc.
//    If !edge_found && acc >= threshold: edge_found=1, edge_index=tap.
//    Then clear acc and rep and increment tap.
//    If tap was NUM_TAPS-1 -> DONE, else -> LAUNCH.
//  DONE (1 cycle): done=1; busy falls on the following cycle.
//  pt_valid/pt_index/pt_count are registered; pt_index/pt_count hold between strobes.
//  threshold=0: tap 0 always hits. threshold>AVG_COUNT: no edge; edge_found stays 0.
//  Start while busy: ignored. Latched threshold is unchanged.
//  Abort (any non-IDLE state): next cycle FSM=IDLE and tx_drive=0, busy=0.
//    No pt_valid and no done. edge_found/edge_index keep whatever was set before.
//  Simultaneous start+abort in IDLE: abort wins, nothing starts.
//  Same cycle as EMIT: abort wins, no pt_valid.
//  rst mid-sweep: immediate return to reset values next cycle, tx_drive=0.
//  Sweep length = NUM_TAPS*(AVG_COUNT*(launch-to-sample + settle) + 1) + 1 cycles.
// STRUCTURE
//  tdr_pkg: typedef enum tdr_sweep_state_e {IDLE, LAUNCH, WAIT, SAMPLE, SETTLE, EMIT, DONE}.
//    Also holds default localparams for NUM_TAPS and AVG_COUNT.
//  Sub-module tdr_point_accumulator: saturating CW-bit counter with clear/inc.
//    Also does the compare against threshold and the first-hit edge capture.
//  Top: FSM plus tap, rep, delay and pulse counters.
// TESTING
//  1 Open line (reflection at 8 cycles, always 1), NUM_TAPS=16, TAP_STEP=1,
//    AVG_COUNT=4, threshold=3 -> taps 0-7 pt_count=0, taps 8-15 pt_count=4;
//    edge_found=1, edge_index=8; exactly 16 pt_valid then one done.
//  2 Launch timing: PULSE_WIDTH=4 -> tx_drive high exactly 4 cycles per launch;
//    pulse_out count = NUM_TAPS*AVG_COUNT = 64; total cycles match the sweep formula.
//  3 Random 50% return, AVG_COUNT=16 -> every pt_count <= 16. With threshold=17,
//    edge_found=0 and done still asserted.
//  4 Abort after the 5th pt_valid -> tx_drive=0 and busy=0 next cycle;
//    no further pt_valid, no done. New start then gives a full clean 16-point sweep.
//  5 start pulsed at tap 3, and start+abort together in IDLE -> sweep unaffected;
//    the second case never starts.
//  6 rst asserted in SETTLE -> all outputs 0 next cycle; after release, start works.

Source files
------------

// File: rtl/tdr_pkg.sv
// Shared types and defaults for the equivalent-time TDR sweep engine.
package tdr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        SAMPLE,
        SETTLE,
        EMIT,
        DONE
    } tdr_sweep_state_e;

    localparam int unsigned DEF_NUM_TAPS  = 64;
    localparam int unsigned DEF_AVG_COUNT = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tdr_point_accumulator.sv
// Saturating per-tap hit counter plus first-tap-over-threshold capture.
module tdr_point_accumulator
    import tdr_pkg::*;
#(
    parameter int unsigned NUM_TAPS  = DEF_NUM_TAPS,
    parameter int unsigned AVG_COUNT = DEF_AVG_COUNT,
    localparam int unsigned CW = $clog2(AVG_COUNT + 1),
    localparam int unsigned TW = $clog2(NUM_TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc_clr,
    input  logic          acc_inc,
    input  logic          edge_clr,
    input  logic          hit_check,
    input  logic [CW-1:0] threshold,
    input  logic [TW-1:0] tap,
    output logic [CW-1:0] count,
    output logic          edge_found,
    output logic [TW-1:0] edge_index
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            edge_found <= 1'b0;
            edge_index <= '0;
        end else begin
            if (acc_clr) begin
                count <= '0;
            end else if (acc_inc && (count != CW'(AVG_COUNT))) begin
                count <= count + 1'b1;
            end

            // Compare uses the pre-clear count when hit_check and acc_clr coincide.
            if (edge_clr) begin
                edge_found <= 1'b0;
                edge_index <= '0;
            end else if (hit_check && !edge_found && (count >= threshold)) begin
                edge_found <= 1'b1;
                edge_index <= tap;
            end
        end
    end

endmodule

// File: rtl/tdr_sweep_capture.sv
// TDR acquisition engine: sweeps the sample tap, averages launches per tap, streams points.
module tdr_sweep_capture
    import tdr_pkg::*;
#(
    parameter int unsigned NUM_TAPS      = DEF_NUM_TAPS,
    parameter int unsigned TAP_STEP      = 1,
    parameter int unsigned AVG_COUNT     = DEF_AVG_COUNT,
    parameter int unsigned PULSE_WIDTH   = 4,
    parameter int unsigned SETTLE_CYCLES = 32,
    localparam int unsigned CW = $clog2(AVG_COUNT + 1),
    localparam int unsigned TW = $clog2(NUM_TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] threshold,
    input  logic          reflected_signal,
    output logic          tx_drive,
    output logic          pulse_out,
    output logic          busy,
    output logic          pt_valid,
    output logic [TW-1:0] pt_index,
    output logic [CW-1:0] pt_count,
    output logic          done,
    output logic          edge_found,
    output logic [TW-1:0] edge_index
);

    localparam int unsigned DMAX        = max_u((NUM_TAPS - 1) * TAP_STEP, PULSE_WIDTH);
    localparam int unsigned DW          = $clog2(DMAX + 1);
    localparam int unsigned SW          = max_u($clog2(SETTLE_CYCLES + 1), 1);
    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    tdr_sweep_state_e state;
    logic [TW-1:0]    tap;
    logic [CW-1:0]    rep;
    logic [CW-1:0]    thr;
    logic [CW-1:0]    acc;
    logic [DW-1:0]    dly;
    logic [SW-1:0]    set_cnt;
    logic             samp;

    logic [DW-1:0] samp_pt;
    logic [DW-1:0] win_end;
    logic          start_ok;
    logic          emit_go;

    // The launch window closes once both the pulse has ended and the sample is taken.
    assign samp_pt  = DW'(tap) * DW'(TAP_STEP);
    assign win_end  = (samp_pt > DW'(PULSE_WIDTH - 1)) ? samp_pt : DW'(PULSE_WIDTH - 1);
    assign start_ok = (state == IDLE) && start && !abort;
    assign emit_go  = (state == EMIT) && !abort;

    tdr_point_accumulator #(
        .NUM_TAPS  (NUM_TAPS),
        .AVG_COUNT (AVG_COUNT)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .acc_clr    (start_ok || emit_go),
        .acc_inc    ((state == SAMPLE) && samp && !abort),
        .edge_clr   (start_ok),
        .hit_check  (emit_go),
        .threshold  (thr),
        .tap        (tap),
        .count      (acc),
        .edge_found (edge_found),
        .edge_index (edge_index)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tap       <= '0;
            rep       <= '0;
            thr       <= '0;
            dly       <= '0;
            set_cnt   <= '0;
            samp      <= 1'b0;
            tx_drive  <= 1'b0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            pt_valid  <= 1'b0;
            pt_index  <= '0;
            pt_count  <= '0;
            done      <= 1'b0;
        end else begin
            pulse_out <= 1'b0;
            pt_valid  <= 1'b0;
            done      <= 1'b0;

            // Delay counter runs from the launch cycle, so tap 0 samples inside the pulse.
            if (((state == LAUNCH) || (state == WAIT)) && (dly == samp_pt)) begin
                samp <= reflected_signal;
            end

            if (abort) begin
                state    <= IDLE;
                tx_drive <= 1'b0;
                busy     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            thr       <= threshold;
                            tap       <= '0;
                            rep       <= '0;
                            busy      <= 1'b1;
                            state     <= LAUNCH;
                            dly       <= '0;
                            tx_drive  <= 1'b1;
                            pulse_out <= 1'b1;
                        end
                    end
                    LAUNCH: begin
                        dly <= dly + 1'b1;
                        if (dly == DW'(PULSE_WIDTH - 1)) begin
                            tx_drive <= 1'b0;
                            state    <= (dly == win_end) ? SAMPLE : WAIT;
                        end
                    end
                    WAIT: begin
                        dly <= dly + 1'b1;
                        if (dly == win_end) begin
                            state <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        set_cnt <= '0;
                        state   <= SETTLE;
                    end
                    SETTLE: begin
                        set_cnt <= set_cnt + 1'b1;
                        if (set_cnt == SW'(SETTLE_LAST)) begin
                            rep <= rep + 1'b1;
                            if (rep == CW'(AVG_COUNT - 1)) begin
                                state <= EMIT;
                            end else begin
                                state     <= LAUNCH;
                                dly       <= '0;
                                tx_drive  <= 1'b1;
                                pulse_out <= 1'b1;
                            end
                        end
                    end
                    EMIT: begin
                        pt_valid <= 1'b1;
                        pt_index <= tap;
                        pt_count <= acc;
                        rep      <= '0;
                        tap      <= tap + 1'b1;
                        if (tap == TW'(NUM_TAPS - 1)) begin
                            state <= DONE;
                        end else begin
                            state     <= LAUNCH;
                            dly       <= '0;
                            tx_drive  <= 1'b1;
                            pulse_out <= 1'b1;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
